// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and frame builder for the UART message arbiter.
package uart_pkg;

    localparam int MSG_W       = 64;
    localparam int PAYLOAD_W   = 40;
    localparam int CHAN_W      = 8;
    localparam int SYNC_W      = 16;
    localparam int PAYLOAD_LSB = 24;
    localparam int CHAN_LSB    = 16;
    localparam int SYNC_LSB    = 0;

    localparam logic [SYNC_W-1:0] SYNC_WORD = 16'h5AA5;
    localparam logic [CHAN_W-1:0] PRI_CHAN  = 8'hFE;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    function automatic logic [MSG_W-1:0] make_frame(input logic [PAYLOAD_W-1:0] p,
                                                    input logic [CHAN_W-1:0] chan);
        logic [MSG_W-1:0] f;
        f = '0;
        f[PAYLOAD_LSB +: PAYLOAD_W] = p;
        f[CHAN_LSB +: CHAN_W]       = chan;
        f[SYNC_LSB +: SYNC_W]       = SYNC_WORD;
        return f;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', with wrap.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    assign any = |req;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin : pick
        logic [IW-1:0] cand;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) grant_idx = cand;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant[gi] = any && (grant_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_msg_arbiter.sv
// Round-robin + priority arbiter framing 40-bit payloads into 64-bit UART FIFO messages.
// Optional stall-drop behaviour is enabled with `define UART_ARB_DROP_EN.
module uart_msg_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4
`ifdef UART_ARB_DROP_EN
    ,
    parameter int DROP_LIMIT = 1024
`endif
) (
    input  logic                      clk_50m,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*PAYLOAD_W-1:0] payload,
    output logic [NREQ-1:0]           ack,
    input  logic                      pri_req,
    input  logic [PAYLOAD_W-1:0]      pri_payload,
    output logic                      pri_ack,
    output logic [MSG_W-1:0]          fifo_data,
    output logic                      fifo_wr,
    input  logic                      fifo_full,
    output logic                      busy,
    output logic [15:0]               drop_cnt
);

    localparam int IW = $clog2(NREQ);

    state_t               state_reg, state_next;
    logic [IW-1:0]        last_reg;
    logic [NREQ-1:0]      rr_grant;
    logic [IW-1:0]        rr_idx;
    logic                 rr_any;
    logic                 pending;
    logic                 grant_go;
    logic                 drop_go;
    logic                 stall_hit;
    logic                 drop_pend;
    logic [PAYLOAD_W-1:0] slot [NREQ];
    logic [MSG_W-1:0]     frame_next;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign slot[gi] = payload[gi*PAYLOAD_W +: PAYLOAD_W];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (req),
        .last      (last_reg),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    assign pending    = pri_req | rr_any;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_next = pri_req ? make_frame(pri_payload, PRI_CHAN)
                                : make_frame(slot[rr_idx], CHAN_W'(rr_idx));

    always_comb begin
        state_next = state_reg;
        grant_go   = 1'b0;
        drop_go    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending && !fifo_full) begin
                    grant_go = 1'b1;
                end else if (pending && stall_hit) begin
                    grant_go = 1'b1;
                    drop_go  = 1'b1;
                end
                if (grant_go) state_next = ST_WRITE;
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Requests are only sampled in IDLE, so a producer dropping req late cannot be re-granted.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            last_reg  <= IW'(NREQ - 1);
            ack       <= '0;
            pri_ack   <= 1'b0;
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
        end else begin
            state_reg <= state_next;
            ack       <= '0;
            pri_ack   <= 1'b0;
            fifo_wr   <= (state_reg == ST_WRITE) && !drop_pend;
            if (grant_go) begin
                if (!drop_go) fifo_data <= frame_next;
                if (pri_req) begin
                    pri_ack <= 1'b1;
                end else begin
                    ack      <= rr_grant;
                    last_reg <= rr_idx;
                end
            end
        end
    end

`ifdef UART_ARB_DROP_EN
    localparam int SW = $clog2(DROP_LIMIT + 1);

    logic [SW-1:0] stall_reg;
    logic          drop_reg;
    logic [15:0]   drop_cnt_reg;

    assign stall_hit = (stall_reg == SW'(DROP_LIMIT));
    assign drop_pend = drop_reg;
    assign drop_cnt  = drop_cnt_reg;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            stall_reg    <= '0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            drop_reg <= drop_go;
            if (grant_go || !fifo_full) begin
                stall_reg <= '0;
            end else if ((state_reg == ST_IDLE) && pending && !stall_hit) begin
                stall_reg <= stall_reg + SW'(1);
            end
            if (drop_go && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign drop_pend = 1'b0;
    assign drop_cnt  = 16'd0;
`endif

endmodule

// File: doc/uart_msg_arbiter.md
Name: uart_msg_arbiter

Overview:
Round-robin arbiter that lets several message producers share the UART transmit message FIFO. It accepts held requests from NREQ producers plus one priority register-read-response source. It frames the selected 40-bit payload as a 64-bit message {payload, channel id, sync word} and writes that message into the FIFO, respecting FIFO backpressure. It sits between the galvo/control producers and the UART transmit FIFO/serializer.

Parameters:
NREQ, 4, number of round-robin producers (2..8)
PAYLOAD_W, 40, payload bits per message (fixed so that PAYLOAD_W+24 = 64)
SYNC_WORD, 16'h5AA5, frame sync header placed in bits [15:0]
PRI_CHAN, 8'hFE, channel id used for priority (register read) frames
DROP_LIMIT, 1024, stall cycles before a drop (used only with the optional feature)

Ports:
clk_50m  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
req  in  NREQ  per-producer request; held high until acked
payload  in  NREQ*PAYLOAD_W  producer payloads, producer i at [i*40 +: 40]
ack  out  NREQ  one-cycle grant pulse; payload was captured on this cycle
pri_req  in  1  priority request (register read response)
pri_payload  in  PAYLOAD_W  priority payload
pri_ack  out  1  one-cycle grant pulse for the priority source
fifo_data  out  64  framed message to the FIFO
fifo_wr  out  1  FIFO write strobe
fifo_full  in  1  FIFO full flag
busy  out  1  high when the FSM is not in IDLE
drop_cnt  out  16  count of dropped frames (optional feature only)

Behaviour:
- Reset (async, rst=1): state=IDLE; ack=0, pri_ack=0, fifo_wr=0, fifo_data=0, busy=0, drop_cnt=0; rr pointer last=NREQ-1, so producer 0 wins first.
- FSM states: IDLE and WRITE.
- IDLE transition: if (pri_req or |req) and !fifo_full, then:
  - pick the winner;
  - latch frame = {winner_payload, chan_id, SYNC_WORD};
  - pulse ack[winner] or pri_ack for one cycle;
  - go to WRITE.
- IDLE otherwise: remain in IDLE with no ack.
- WRITE: fifo_wr=1 for exactly one cycle with fifo_data=frame; return to IDLE. fifo_data holds its value after the write.
- Channel id: producer i uses 8'(i); the priority source uses PRI_CHAN.
- Arbitration:
  - pri_req beats every producer and does not move the pointer.
  - Otherwise, search from last+1 mod NREQ upward with wrap; on grant, last<=winner.
  - A continuously requesting producer waits at most NREQ-1 grants (no starvation).
- Latency and throughput:
  - req high -> ack on the next rising edge.
  - ack cycle -> fifo_wr on the following cycle.
  - Peak throughput is 1 frame per 2 cycles.
- Handshake:
  - req/payload must stay stable until ack is seen.
  - A producer drops req the cycle after ack; the arbiter ignores req during WRITE, so a late drop cannot cause a double grant.
  - A req withdrawn before ack produces no frame and no ack.
- Full: sampled in IDLE only. This block is the FIFO's sole writer, so full cannot rise between IDLE and WRITE; a write is never issued into a full FIFO.
- Simultaneous events: pri_req together with all req -> pri granted; the producers follow in rr order.
- Reset mid-WRITE: fifo_wr deasserts immediately; the frame is lost; producers see no ack for it.

Optional Feature:
Macro UART_ARB_DROP_EN.
- Defined:
  - A counter runs while the FSM is in IDLE with a pending request and fifo_full=1.
  - When the counter reaches DROP_LIMIT, the pending winner is acked as normal, no write is issued, and drop_cnt increments (saturating at 16'hFFFF).
  - The counter clears on any grant or when full deasserts.
- Undefined: the arbiter stalls indefinitely under full; drop_cnt is tied to 0.

Decomposition:
- Package uart_pkg: SYNC_WORD, PRI_CHAN, MSG_W=64, PAYLOAD_W=40, FSM state encodings, frame field offsets (payload [63:24], chan [23:16], sync [15:0]).
- Sub-module rr_pick: combinational NREQ-wide round-robin picker taking (req, last) and producing (grant_onehot, grant_idx, any). It is reused by future register-bus arbitration.

Test Plan:
- Single request: req=4'b0001 with payload0=40'h12_3456_789A -> ack[0] at cycle+1; fifo_wr at cycle+2 with fifo_data=64'h123456789A_00_5AA5.
- Round robin: req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0; per-grant fifo_data chan fields 00,01,02,03,00.
- Priority: pri_req=1 with pri_payload=40'hAB and req=4'b0010 in the same cycle -> pri_ack first with chan FE; ack[1] two cycles later; pointer unchanged.
- Backpressure: fifo_full=1 with req=4'b0100 for 50 cycles -> no ack, no fifo_wr, busy=0; full drops -> ack[2] next cycle, write follows.
- Reset mid-operation: rst=1 asserted during WRITE -> fifo_wr=0 the same cycle; after release with req=4'b1000 -> ack[3] granted; with req=4'b1001 -> ack[0] granted (pointer reset).
- UART_ARB_DROP_EN, DROP_LIMIT=8: full held with req=4'b0001 -> ack[0] after 8 stall cycles, no fifo_wr, drop_cnt=1.
